// File: rtl/seq_pc_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | seq_pc_ctrl_if : fetch/execute/data-memory signal bundle for the        |
// |                  SEQ program-counter controller.                        |
// | Revision 1.0                                                            |
// +------------------------------------------------------------------------+
interface seq_pc_ctrl_if;
  logic [3:0]  icode;
  logic [63:0] valC;
  logic [63:0] valP;
  logic        instr_valid;
  logic        imem_error;
  logic        cnd;
  logic        stall;
  logic        mem_ack;
  logic        dmem_error;
  logic [63:0] valM;
  logic [63:0] pc;
  logic [2:0]  stat;
  logic        mem_req;
  logic        commit;
  logic [63:0] retired;

  modport master (
    input  icode, valC, valP, instr_valid, imem_error, cnd, stall,
           mem_ack, dmem_error, valM,
    output pc, stat, mem_req, commit, retired
  );

  modport slave (
    output icode, valC, valP, instr_valid, imem_error, cnd, stall,
           mem_ack, dmem_error, valM,
    input  pc, stat, mem_req, commit, retired
  );
endinterface
`default_nettype wire

// File: rtl/seq_pc_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | seq_pc_ctrl : SEQ fetch-stage PC sequencer with data-memory handshake   |
// |               and Y86-64 status tracking. Optional retired-instruction  |
// |               counter enabled by macro SEQ_RETIRE_CNT_EN.               |
// | Revision 1.0                                                            |
// +------------------------------------------------------------------------+
module seq_pc_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input wire           clk,
  input wire           rst_n,
  seq_pc_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_MEM  = 2'd1,
    S_HALT = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  state_t      state, state_nx;
  logic [63:0] pc, pc_nx;
  logic [2:0]  stat, stat_nx;
  logic        mem_req, mem_req_nx;
  logic        commit, commit_nx;
  logic        is_mem_class;
  logic [63:0] next_pc;

  always_comb begin
    is_mem_class = (bus.icode == I_RMMOVQ) || (bus.icode == I_MRMOVQ) ||
                   (bus.icode == I_CALL)   || (bus.icode == I_RET)    ||
                   (bus.icode == I_PUSHQ)  || (bus.icode == I_POPQ);
  end

  // valM is only consumed on the MEM->RUN edge, where mem_ack qualifies it.
  always_comb begin
    next_pc = bus.valP;
    if (bus.icode == I_CALL) begin
      next_pc = bus.valC;
    end else if ((bus.icode == I_JXX) && bus.cnd) begin
      next_pc = bus.valC;
    end else if (bus.icode == I_RET) begin
      next_pc = bus.valM;
    end
  end

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    stat_nx    = stat;
    mem_req_nx = 1'b0;
    commit_nx  = 1'b0;
    case (state)
      S_RUN: begin
        if (bus.imem_error) begin
          state_nx = S_ERR;
          stat_nx  = STAT_ADR;
        end else if (!bus.instr_valid) begin
          state_nx = S_ERR;
          stat_nx  = STAT_INS;
        end else if (bus.icode == I_HALT) begin
          state_nx = S_HALT;
          stat_nx  = STAT_HLT;
        end else if (bus.stall) begin
          state_nx = S_RUN;
        end else if (is_mem_class) begin
          state_nx   = S_MEM;
          mem_req_nx = 1'b1;
        end else begin
          pc_nx     = next_pc;
          commit_nx = 1'b1;
        end
      end
      S_MEM: begin
        mem_req_nx = 1'b1;
        if (bus.mem_ack) begin
          mem_req_nx = 1'b0;
          if (bus.dmem_error) begin
            state_nx = S_ERR;
            stat_nx  = STAT_ADR;
          end else begin
            state_nx  = S_RUN;
            pc_nx     = next_pc;
            commit_nx = 1'b1;
          end
        end
      end
      default: begin
        state_nx = state;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_RUN;
      pc      <= RESET_PC;
      stat    <= STAT_AOK;
      mem_req <= 1'b0;
      commit  <= 1'b0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      stat    <= stat_nx;
      mem_req <= mem_req_nx;
      commit  <= commit_nx;
    end
  end

`ifdef SEQ_RETIRE_CNT_EN
  logic [63:0] retired_cnt;

  // Counts alongside the PC update, so it tracks commit with no extra lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= 64'd0;
    end else if (commit_nx) begin
      retired_cnt <= retired_cnt + 64'd1;
    end
  end

  assign bus.retired = retired_cnt;
`else
  assign bus.retired = 64'd0;
`endif

  assign bus.pc      = pc;
  assign bus.stat    = stat;
  assign bus.mem_req = mem_req;
  assign bus.commit  = commit;

endmodule
`default_nettype wire
